// File: rtl/issue_ctrl.sv
// issue_ctrl: issue/hazard controller between operand fetch and EX.
// Each architectural register has a countdown timer for results that are still
// in flight. The controller stalls decode on RAW/WAW hazards against those
// timers and while the MUL/DIV unit is busy. It also sequences a pipeline drain
// (RUN -> DRAIN -> DONE) for CSR, system and fence instructions.
// Optional build macro: ISSUE_STALL_CNT_EN adds the stall_data_cnt and
// stall_struct_cnt counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal issue; hazards gate dec_ready
// ST_DRAIN | no issue; waiting for every timer and md_cnt to reach zero
// ST_DONE  | drain_done is high this cycle; returns to ST_RUN
module issue_ctrl #(
    parameter int LOAD_LAT   = 2,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] dec_rd,
    input  logic       dec_uses_rs1,
    input  logic       dec_uses_rs2,
    input  logic       dec_writes_rd,
    input  logic [1:0] dec_class,
    input  logic       flush,
    input  logic       drain_req,
    output logic       dec_ready,
    output logic       issue_valid,
    output logic [4:0] issue_rd,
    output logic [1:0] stall_cause,
    output logic       drain_done
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0] stall_data_cnt,
    output logic [31:0] stall_struct_cnt
`endif
);

    localparam logic [1:0] CLS_LOAD   = 2'd1;
    localparam logic [1:0] CLS_MULDIV = 2'd2;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q   [32];
    logic [CNT_W-1:0] timer_dec [32];
    logic [CNT_W-1:0] md_cnt_q, md_dec, new_lat;
    logic             raw, waw, md_busy, fire, quiet_nxt;

    // Result latency of the instruction in decode
    always_comb begin
        new_lat = '0;
        case (dec_class)
            CLS_LOAD:   new_lat = CNT_W'(LOAD_LAT);
            CLS_MULDIV: new_lat = CNT_W'(MULDIV_LAT);
            default:    new_lat = '0;
        endcase
    end

    // Saturating decrement of all timers; quiet_nxt means everything is zero next cycle
    always_comb begin
        quiet_nxt = 1'b1;
        for (int i = 0; i < 32; i++) begin
            timer_dec[i] = (timer_q[i] != '0) ? timer_q[i] - CNT_W'(1) : '0;
            if (timer_dec[i] != '0) quiet_nxt = 1'b0;
        end
        md_dec = (md_cnt_q != '0) ? md_cnt_q - CNT_W'(1) : '0;
        if (md_dec != '0) quiet_nxt = 1'b0;
    end

    // Hazard detection, issue handshake and stall classification
    always_comb begin
        raw = (dec_uses_rs1 && timer_q[dec_rs1] != '0) ||
              (dec_uses_rs2 && timer_q[dec_rs2] != '0);
        waw = dec_writes_rd && (timer_q[dec_rd] > new_lat);
        md_busy = (dec_class == CLS_MULDIV) && (md_cnt_q != '0);
        dec_ready = (state_q == ST_RUN) && !drain_req && !flush && !raw && !waw && !md_busy;
        fire = dec_valid && dec_ready;
        stall_cause = 2'd0;
        if (dec_valid && !dec_ready) begin
            if (flush || drain_req || state_q != ST_RUN) stall_cause = 2'd3;
            else if (raw || waw)                         stall_cause = 2'd1;
            else if (md_busy)                            stall_cause = 2'd2;
        end
    end

    // Scoreboard timers: a new producer's load overrides the decrement; r0 never busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q  <= '{default: '0};
            md_cnt_q <= '0;
        end else begin
            timer_q[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (fire && dec_writes_rd && dec_rd == 5'(i) && new_lat != '0)
                    timer_q[i] <= new_lat;
                else
                    timer_q[i] <= timer_dec[i];
            end
            if (fire && dec_class == CLS_MULDIV) md_cnt_q <= CNT_W'(MULDIV_LAT);
            else                                 md_cnt_q <= md_dec;
        end
    end

    // Drain sequencer next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (quiet_nxt) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State register and registered issue/drain outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            issue_valid <= 1'b0;
            issue_rd    <= '0;
            drain_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_valid <= fire;
            issue_rd    <= (fire && dec_writes_rd) ? dec_rd : '0;
            drain_done  <= (state_q == ST_DRAIN) && quiet_nxt;
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    // Stall statistics; free-running, wrap at 2**32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_data_cnt   <= '0;
            stall_struct_cnt <= '0;
        end else begin
            if (stall_cause == 2'd1) stall_data_cnt   <= stall_data_cnt + 32'd1;
            if (stall_cause == 2'd2) stall_struct_cnt <= stall_struct_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl. A reference model tracks, for each register, the
// absolute cycle at which its result becomes available, and tracks when any
// drain in progress completes. Expected per-cycle outputs are queued, and a
// monitor on the falling edge pops the entries and compares them.
module tb_issue_ctrl;
    localparam int LOAD_LAT   = 2;
    localparam int MULDIV_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_uses_rs1, dec_uses_rs2, dec_writes_rd, flush, drain_req;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic [1:0] dec_class;
    logic       dec_ready, issue_valid, drain_done;
    logic [4:0] issue_rd;
    logic [1:0] stall_cause;

    issue_ctrl #(.LOAD_LAT(LOAD_LAT), .MULDIV_LAT(MULDIV_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_writes_rd(dec_writes_rd), .dec_class(dec_class), .flush(flush),
        .drain_req(drain_req), .dec_ready(dec_ready), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .stall_cause(stall_cause), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic [1:0] cause;
        logic       ivalid;
        logic       ddone;
        int         cyc;
    } st_t;

    st_t        st_q[$];
    logic [4:0] iss_q[$];
    st_t        mon_s;
    int  checks = 0, passes = 0;
    int  cyc = 0;
    bit  chk_en = 0;
    int  ready_at[32];
    int  md_ready, run_resume, done_cyc;
    bit  prev_fire, last_done;

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    endtask

    function automatic int lat_of(input int cls);
        if (cls == 1) return LOAD_LAT;
        if (cls == 2) return MULDIV_LAT;
        return 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        md_ready   = 0;
        run_resume = 0;
        done_cyc   = -1;
        prev_fire  = 0;
        st_q.delete();
        iss_q.delete();
    endtask

    // Drive one cycle of decode inputs, predict the outputs, advance the clock
    task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                        input bit u1, input bit u2, input bit wr, input int cls,
                        input bit fl, input bit dr);
        st_t s;
        int  lat, t_rd, q;
        bit  run, raw, waw, sb, rdy, fire;
        dec_valid = v; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd);
        dec_uses_rs1 = u1; dec_uses_rs2 = u2; dec_writes_rd = wr;
        dec_class = 2'(cls); flush = fl; drain_req = dr;
        lat  = lat_of(cls);
        run  = (cyc >= run_resume);
        raw  = (u1 && ready_at[rs1] > cyc) || (u2 && ready_at[rs2] > cyc);
        t_rd = (ready_at[rd] > cyc) ? ready_at[rd] - cyc : 0;
        waw  = wr && (t_rd > lat);
        sb   = (cls == 2) && (md_ready > cyc);
        rdy  = run && !dr && !fl && !raw && !waw && !sb;
        fire = v && rdy;
        s.ready = rdy;
        if (!v || rdy)                s.cause = 2'd0;
        else if (fl || dr || !run)    s.cause = 2'd3;
        else if (raw || waw)          s.cause = 2'd1;
        else                          s.cause = 2'd2;
        s.ivalid = prev_fire;
        s.ddone  = (cyc == done_cyc);
        s.cyc    = cyc;
        last_done = s.ddone;
        st_q.push_back(s);
        if (fire) begin
            iss_q.push_back(wr ? 5'(rd) : 5'd0);
            if (wr && rd != 0 && lat != 0) ready_at[rd] = cyc + lat + 1;
            if (cls == 2) md_ready = cyc + MULDIV_LAT + 1;
        end else if (run && dr) begin
            q = md_ready;
            for (int r = 0; r < 32; r++) if (ready_at[r] > q) q = ready_at[r];
            done_cyc   = (cyc + 2 > q) ? cyc + 2 : q;
            run_resume = done_cyc + 1;
        end
        prev_fire = fire;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock edge
    task automatic async_reset(input int exp_iv, input int exp_ird);
        chk_en = 0;
        #2;
        chk("pre_rst_issue_valid", cyc, int'(issue_valid), exp_iv);
        chk("pre_rst_issue_rd", cyc, int'(issue_rd), exp_ird);
        rst = 1'b1;
        #1;
        chk("rst_issue_valid", cyc, int'(issue_valid), 0);
        chk("rst_issue_rd", cyc, int'(issue_rd), 0);
        chk("rst_drain_done", cyc, int'(drain_done), 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        chk_en = 1;
    endtask

    // Scoreboard monitor: compares each queued expectation against the DUT
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (st_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_underflow cycle %0d: got no expectation, required one", cyc);
            end else begin
                mon_s = st_q.pop_front();
                chk("dec_ready", mon_s.cyc, int'(dec_ready), int'(mon_s.ready));
                chk("stall_cause", mon_s.cyc, int'(stall_cause), int'(mon_s.cause));
                chk("issue_valid", mon_s.cyc, int'(issue_valid), int'(mon_s.ivalid));
                chk("drain_done", mon_s.cyc, int'(drain_done), int'(mon_s.ddone));
                if (issue_valid) begin
                    if (iss_q.size() == 0) begin
                        checks++;
                        $display("FAIL issue_rd cycle %0d: got unexpected issue rd=%0d, required none",
                                 mon_s.cyc, issue_rd);
                    end else begin
                        chk("issue_rd", mon_s.cyc, int'(issue_rd), int'(iss_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        bit drain_on;
        int cls;
        rst = 1'b1;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_uses_rs1 = 0;
        dec_uses_rs2 = 0; dec_writes_rd = 0; dec_class = 0; flush = 0; drain_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;

        // load r5 then dependent ADD: stalls two cycles
        step(1, 0, 0, 5, 1, 0, 1, 1, 0, 0);
        repeat (3) step(1, 5, 6, 10, 1, 1, 1, 0, 0, 0);
        idle(2);
        // MUL r6 then independent DIV r7: structural stall four cycles
        step(1, 1, 2, 6, 1, 1, 1, 2, 0, 0);
        repeat (5) step(1, 1, 2, 7, 1, 1, 1, 2, 0, 0);
        idle(5);
        // load r0 then ADD reading r0: no stall
        step(1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 11, 1, 1, 1, 0, 0, 0);
        idle(2);
        // MUL r8 then ADDI r8: WAW stall; ALU to ALU on the same rd never stalls
        step(1, 1, 2, 8, 1, 1, 1, 2, 0, 0);
        repeat (5) step(1, 1, 0, 8, 1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 9, 1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 9, 1, 0, 1, 0, 0, 0);
        idle(5);
        // flush kills the slot while a pending load keeps counting
        step(1, 1, 0, 4, 1, 0, 1, 1, 0, 0);
        step(1, 2, 0, 12, 1, 0, 1, 0, 1, 0);
        repeat (2) step(1, 4, 0, 12, 1, 0, 1, 0, 0, 0);
        idle(2);
        // load r3 then drain: done pulse two cycles after the request, RUN after that
        step(1, 1, 0, 3, 1, 0, 1, 1, 0, 0);
        repeat (3) step(1, 3, 0, 13, 1, 0, 1, 0, 0, 1);
        step(1, 3, 0, 13, 1, 0, 1, 0, 0, 0);
        idle(2);
        // reset during a drain discards the busy MUL/DIV unit
        step(1, 1, 2, 14, 1, 1, 1, 2, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        async_reset(0, 0);
        step(1, 1, 2, 15, 1, 1, 1, 2, 0, 0);
        idle(2);
        // reset the cycle after a load issues
        step(1, 1, 0, 9, 1, 0, 1, 1, 0, 0);
        async_reset(1, 9);
        step(1, 9, 0, 16, 1, 0, 1, 0, 0, 0);
        idle(2);

        // randomized traffic with occasional flushes and drains
        drain_on = 0;
        for (int n = 0; n < 3000; n++) begin
            cls = $urandom_range(0, 3);
            step($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                 (cls != 3) && ($urandom_range(0, 3) != 0), cls,
                 $urandom_range(0, 11) == 0, drain_on);
            if (last_done) drain_on = 0;
            else if (!drain_on && $urandom_range(0, 49) == 0) drain_on = 1;
        end
        idle(8);
        chk("issue_queue_drained", cyc, iss_q.size(), 0);
        chk_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
